// File: rtl/fir_output_quantizer_pkg.sv
// fir_output_quantizer_pkg
//   Shared FIR definitions: filter datapath widths, the default widths of the
//   output quantizer and the saturation limits of the quantized sample.
//   No ports; imported by the quantizer files.
package fir_output_quantizer_pkg;

    // Filter datapath: 16-bit samples times 16-bit coefficients summed over
    // 8 taps gives a 35-bit full-precision accumulator.
    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_COEF_WIDTH = 16;
    localparam int FIR_TAPS       = 8;
    localparam int FIR_ACC_WIDTH  = FIR_DATA_WIDTH + FIR_COEF_WIDTH + $clog2(FIR_TAPS);

    // Output quantizer defaults.
    localparam int QUANT_IN_WIDTH   = FIR_ACC_WIDTH;
    localparam int QUANT_OUT_WIDTH  = 16;
    localparam int QUANT_FRAC_SHIFT = 15;
    localparam int QUANT_CNT_WIDTH  = 16;

    // Saturation limits of a QUANT_OUT_WIDTH signed sample.
    localparam logic [QUANT_OUT_WIDTH-1:0] QUANT_SAT_MAX = {1'b0, {(QUANT_OUT_WIDTH-1){1'b1}}};
    localparam logic [QUANT_OUT_WIDTH-1:0] QUANT_SAT_MIN = {1'b1, {(QUANT_OUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fir_output_quantizer_quant_skid_fifo.sv
// quant_skid_fifo
//   Two-entry FIFO whose head is held in registers and drives the outputs
//   directly. Handshake on both sides: a word moves in a cycle where valid
//   and ready are both 1; valid never depends on ready of the same side.
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     in_valid_i/in_ready_o  write side handshake, in_data_i word
//     out_valid_o/out_ready_i read side handshake, out_data_o head word
module quant_skid_fifo
    import fir_output_quantizer_pkg::*;
#(
    parameter int W = QUANT_OUT_WIDTH + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic         head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic         push, pop;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready_o  = ~tail_vld_q | out_ready_i;
    assign out_valid_o = head_vld_q;
    assign out_data_o  = head_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = head_vld_q & out_ready_i;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        case ({head_vld_q, tail_vld_q})
            2'b00: begin
                if (push) begin
                    head_d     = in_data_i;
                    head_vld_d = 1'b1;
                end
            end
            2'b10: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d     = in_data_i;
                    tail_vld_d = 1'b1;
                end else if (pop) begin
                    head_vld_d = 1'b0;
                end
            end
            2'b11: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = in_data_i;
                    end else begin
                        tail_vld_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

endmodule

// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer
//   Rounds (half-up) and saturates the full-precision FIR result to an
//   OUT_WIDTH sample. One stage-1 register feeds a 2-entry output FIFO whose
//   head drives the outputs. Counts saturated samples (sticky at all-ones).
//   Ports:
//     clk, reset (async, active-low)
//     in_data/in_valid/in_ready     input sample handshake
//     out_data/out_sat/out_valid/out_ready  output sample handshake
//     clr_count                     synchronous clear of sat_count
//     sat_count                     saturated-sample counter
module fir_output_quantizer
    import fir_output_quantizer_pkg::*;
#(
    parameter int IN_WIDTH   = QUANT_IN_WIDTH,
    parameter int OUT_WIDTH  = QUANT_OUT_WIDTH,
    parameter int FRAC_SHIFT = QUANT_FRAC_SHIFT,
    parameter int CNT_WIDTH  = QUANT_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clr_count,
    output logic [CNT_WIDTH-1:0]        sat_count
);

    localparam int EXT_W = IN_WIDTH + 1;
    localparam logic signed [IN_WIDTH:0] RND_HALF = EXT_W'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] R_MAX =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] R_MIN =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] SAT_HI_CODE = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_LO_CODE = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    // Round/saturate, one extra bit so the rounding add never wraps.
    logic signed [IN_WIDTH:0] ext, sum, r;
    logic                     sat_hi, sat_lo, q_sat;
    logic [OUT_WIDTH-1:0]     q_data;

    assign ext    = {in_data[IN_WIDTH-1], in_data};
    assign sum    = ext + RND_HALF;
    assign r      = sum >>> FRAC_SHIFT;
    assign sat_hi = (r > R_MAX);
    assign sat_lo = (r < R_MIN);
    assign q_sat  = sat_hi | sat_lo;
    assign q_data = sat_hi ? SAT_HI_CODE : (sat_lo ? SAT_LO_CODE : r[OUT_WIDTH-1:0]);

    logic                 s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
    logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]           occ_q, occ_d;
    logic [CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
    logic                 accept, out_fire, fifo_in_ready, s1_move;
    logic [OUT_WIDTH:0]   fifo_out;

    // occ counts stage-1 plus FIFO. Whenever occ < 3 and stage-1 is full,
    // the FIFO holds at most one word, so stage-1 drains in the same cycle
    // and a new sample can always be loaded.
    assign in_ready = (occ_q != 2'd3);
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign s1_move  = s1_valid_q & fifo_in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = q_data;
            s1_sat_d   = q_sat;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        occ_d = occ_q;
        if (accept && !out_fire) begin
            occ_d = occ_q + 2'd1;
        end else if (!accept && out_fire) begin
            occ_d = occ_q - 2'd1;
        end

        // Clear beats a same-cycle saturating accept.
        sat_cnt_d = sat_cnt_q;
        if (clr_count) begin
            sat_cnt_d = '0;
        end else if (accept && q_sat && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sat_q   <= 1'b0;
            occ_q      <= 2'd0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sat_q   <= s1_sat_d;
            occ_q      <= occ_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    quant_skid_fifo #(
        .W(OUT_WIDTH + 1)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .in_valid_i (s1_valid_q),
        .in_ready_o (fifo_in_ready),
        .in_data_i  ({s1_sat_q, s1_data_q}),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (fifo_out)
    );

    assign out_sat   = fifo_out[OUT_WIDTH];
    assign out_data  = fifo_out[OUT_WIDTH-1:0];
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb_fir_output_quantizer
//   Bench for fir_output_quantizer with default data widths and a 4-bit
//   saturation counter so the sticky limit is reachable quickly.
module tb_fir_output_quantizer;

    localparam int IN_W  = 35;
    localparam int OUT_W = 16;
    localparam int FRAC  = 15;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    clr_count = 1'b0;
    logic [CNT_W-1:0]        sat_count;

    fir_output_quantizer #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .FRAC_SHIFT(FRAC),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clr_count(clr_count),
        .sat_count(sat_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- counters / check ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: round half up by floor((x + 2^(FRAC-1)) / 2^FRAC), then clip.
    function automatic logic [OUT_W:0] model_q(input longint x);
        longint r;
        r = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(r)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [OUT_W:0] exp_q[$];
    int             sat_model = 0;
    bit             stall_q = 1'b0;
    logic [OUT_W:0] held_q = '0;
    logic [OUT_W:0] mon_e;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            exp_q.delete();
            sat_model = 0;
            stall_q = 1'b0;
        end else begin
            check("sat_count", 64'(sat_count), 64'(sat_model));
            if (stall_q) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'({out_sat, out_data}), 64'(held_q));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_unexpected: got 0x%0h with no sample pending", {out_sat, out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_sample", 64'({out_sat, out_data}), 64'(mon_e));
                end
            end
            if (in_valid && in_ready) begin
                mon_e = model_q(longint'(in_data));
                exp_q.push_back(mon_e);
                if (mon_e[OUT_W] && !clr_count && sat_model < CNT_MAX) sat_model++;
            end
            if (clr_count) sat_model = 0;
            stall_q = out_valid && !out_ready;
            held_q  = {out_sat, out_data};
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        longint           din;
        logic [OUT_W-1:0] dout;
        logic             sat;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [IN_W-1:0] rnd_in();
        longint base;
        case ($urandom_range(0, 2))
            0: rnd_in = IN_W'({$urandom, $urandom});
            1: begin
                base = (longint'($urandom_range(0, 65535)) - 32768) * 32768;
                rnd_in = IN_W'(base + longint'($urandom_range(0, 65535)) - 32768);
            end
            default: begin
                base = ($urandom_range(0, 1) == 1) ? 32767 * 32768 : -32768 * 32768;
                rnd_in = IN_W'(base + longint'($urandom_range(0, 131071)) - 65536);
            end
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n_sat_tbl;
        int k, acc, nout, last;
        int waited;
        bit seen;

        tbl[0]  = '{16384,                    16'h0001, 1'b0};
        tbl[1]  = '{-16384,                   16'h0000, 1'b0};
        tbl[2]  = '{16383,                    16'h0000, 1'b0};
        tbl[3]  = '{64'sd2147483648,          16'h7FFF, 1'b1};
        tbl[4]  = '{-64'sd8589934592,         16'h8000, 1'b1};
        tbl[5]  = '{32767 * 32768 + 16383,    16'h7FFF, 1'b0};
        tbl[6]  = '{32767 * 32768 + 16384,    16'h7FFF, 1'b1};
        tbl[7]  = '{-32768 * 32768,           16'h8000, 1'b0};
        tbl[8]  = '{-32768 * 32768 - 16385,   16'h8000, 1'b1};
        tbl[9]  = '{64'sd17179869183,         16'h7FFF, 1'b1};
        tbl[10] = '{-64'sd17179869184,        16'h8000, 1'b1};
        tbl[11] = '{-1,                       16'h0000, 1'b0};
        tbl[12] = '{-16385,                   16'hFFFF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #3;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Table: single samples, latency 2 with empty pipeline
        n_sat_tbl = 0;
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            in_data  = IN_W'(tbl[i].din);
            in_valid = 1'b1;
            #3 check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #3 check($sformatf("tbl%0d_early", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            #3;
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].dout));
            check($sformatf("tbl%0d_sat", i), 64'(out_sat), 64'(tbl[i].sat));
            if (tbl[i].sat) n_sat_tbl++;
        end
        @(negedge clk);
        #3 check("tbl_sat_count", 64'(sat_count), 64'(n_sat_tbl));

        // Stream 1..10 with out_ready low for cycles 0..5
        k = 1; acc = 0; nout = 0; last = -1;
        for (int c = 0; c < 80 && nout < 10; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            in_valid  = (k <= 10);
            in_data   = IN_W'(longint'(k) <<< FRAC);
            #3;
            if (c == 3) begin
                check("stream_in_ready_low", 64'(in_ready), 64'd0);
                check("stream_accepts", 64'(acc), 64'd3);
            end
            if (in_valid && in_ready) begin
                k++;
                acc++;
            end
            if (out_valid && out_ready) begin
                check("stream_data", 64'(out_data), 64'(nout + 1));
                if (nout > 0) check("stream_gap", 64'(c - last), 64'd1);
                last = c;
                nout++;
            end
        end
        check("stream_count", 64'(nout), 64'd10);
        @(negedge clk);
        in_valid = 1'b0;

        // Reset with occ=3
        out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = rnd_in();
            #3;
            if (!in_ready) seen = 1'b1;
        end
        check("fill_to_full", 64'(seen), 64'd1);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_sat_count", 64'(sat_count), 64'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = IN_W'(longint'(7) <<< FRAC);
        #3 check("postrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (waited = 0; waited < 6 && !seen; waited++) begin
            #3;
            if (out_valid) begin
                seen = 1'b1;
                check("postrst_first_data", 64'(out_data), 64'd7);
            end
            @(negedge clk);
        end
        check("postrst_output_seen", 64'(seen), 64'd1);

        // sat_count sticky limit and clear priority
        repeat (CNT_MAX + 5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = IN_W'(64'sd2147483648);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 check("sat_sticky", 64'(sat_count), 64'(CNT_MAX));
        @(negedge clk);
        in_valid  = 1'b1;
        clr_count = 1'b1;
        in_data   = IN_W'(-64'sd8589934592);
        @(negedge clk);
        in_valid  = 1'b0;
        clr_count = 1'b0;
        #3 check("sat_clear_wins", 64'(sat_count), 64'd0);
        repeat (4) @(negedge clk);

        // Random traffic
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            clr_count = ($urandom_range(0, 63) == 0);
            in_data   = rnd_in();
            #3;
            if (in_valid && in_ready) acc++;
        end
        check("rand_accepts", 64'(acc), 64'd10000);
        @(negedge clk);
        in_valid  = 1'b0;
        clr_count = 1'b0;
        out_ready = 1'b1;
        for (waited = 0; waited < 20 && exp_q.size() != 0; waited++) @(negedge clk);
        #3 check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
